fifo_wr_ctrl: RTL and testbench

Write-side controller for the dual-clock FIFO, sitting directly upstream of the dual-port memory's write port in the wrClk domain. It accepts push requests, drives the memory's `writeEn`/`addrIn`/`dataIn`, and maintains a binary and Gray-coded write pointer. It synchronizes the read-domain Gray pointer into wrClk, derives the full flag and fill count, and flags overflow.

---
 rtl/fifo_wr_ctrl.sv | 100 ++++++++++
 tb/tb_fifo_wr_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the dual-clock FIFO: push acceptance, memory write port,
// binary/Gray write pointer, read-pointer synchronizer, full/count/overflow flags.
// Optional almost-full threshold is built only when FIFO_WR_CTRL_ALMOST_FULL_EN is defined.
module fifo_wr_ctrl #(
  parameter int FIFO_WIDTH         = 8,
  parameter int FIFO_DEPTH         = 64,
  parameter int ADDR_WIDTH         = 6,
  parameter int ALMOST_FULL_MARGIN = 4
) (
  input  logic                  wrClk,
  input  logic                  rst,
  input  logic                  wrEn,
  input  logic [FIFO_WIDTH-1:0] wrData,
  output logic                  wrFull,
  output logic                  almostFull,
  output logic                  wrErr,
  output logic [ADDR_WIDTH:0]   wrCount,
  input  logic [ADDR_WIDTH:0]   rdPtrGray,
  output logic [ADDR_WIDTH:0]   wrPtrGray,
  output logic                  memWriteEn,
  output logic [ADDR_WIDTH-1:0] memAddrIn,
  output logic [FIFO_WIDTH-1:0] memDataIn
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] wr_bin_q, wr_bin_d;
  logic [PW-1:0] wr_gray_q, wr_gray_d;
  logic [PW-1:0] sync1_q, sync2_q;
  logic [PW-1:0] rd_bin_sync;
  logic [PW-1:0] full_gray;
  logic [PW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          err_q, err_d;
  logic          accept;

  assign accept = wrEn & ~full_q & ~rst;

  always_comb begin
    wr_bin_d  = wr_bin_q + {{(PW-1){1'b0}}, accept};
    wr_gray_d = wr_bin_d ^ (wr_bin_d >> 1);
    // Each binary bit is the XOR of all Gray bits at or above it.
    rd_bin_sync = '0;
    for (int i = 0; i < PW; i++) begin
      rd_bin_sync[i] = ^(sync2_q >> i);
    end
    // Full when the write pointer leads the read pointer by exactly one lap.
    full_gray = {~sync2_q[PW-1:PW-2], sync2_q[PW-3:0]};
    full_d    = (wr_gray_d == full_gray);
    count_d   = wr_bin_d - rd_bin_sync;
    err_d     = err_q | (wrEn & full_q);
  end

  always_ff @(posedge wrClk or posedge rst) begin
    if (rst) begin
      wr_bin_q  <= '0;
      wr_gray_q <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_bin_q  <= wr_bin_d;
      wr_gray_q <= wr_gray_d;
      sync1_q   <= rdPtrGray;
      sync2_q   <= sync1_q;
      count_q   <= count_d;
      full_q    <= full_d;
      err_q     <= err_d;
    end
  end

`ifdef FIFO_WR_CTRL_ALMOST_FULL_EN
  localparam logic [PW-1:0] AF_THRESH = PW'(FIFO_DEPTH - ALMOST_FULL_MARGIN);

  logic af_q, af_d;

  assign af_d = (count_d >= AF_THRESH);

  always_ff @(posedge wrClk or posedge rst) begin
    if (rst) af_q <= 1'b0;
    else     af_q <= af_d;
  end

  assign almostFull = af_q;
`else
  assign almostFull = 1'b0;
`endif

  assign wrFull     = full_q;
  assign wrErr      = err_q;
  assign wrCount    = count_q;
  assign wrPtrGray  = wr_gray_q;
  // Memory port is combinational so the word lands on the edge that advances the pointer.
  assign memWriteEn = accept;
  assign memAddrIn  = wr_bin_q[ADDR_WIDTH-1:0];
  assign memDataIn  = wrData;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl: directed scenarios plus a randomized run, all
// compared against a pointer-arithmetic model of the FIFO write side.
module tb_fifo_wr_ctrl;

  localparam int W  = 8;
  localparam int A  = 6;
  localparam int D  = 64;
  localparam int M  = 4;
  localparam int PW = A + 1;
  localparam int MOD = 2 * D;
`ifdef FIFO_WR_CTRL_ALMOST_FULL_EN
  localparam bit AF_EN = 1'b1;
`else
  localparam bit AF_EN = 1'b0;
`endif

  logic          wrClk;
  logic          rst;
  logic          wrEn;
  logic [W-1:0]  wrData;
  logic          wrFull;
  logic          almostFull;
  logic          wrErr;
  logic [PW-1:0] wrCount;
  logic [PW-1:0] rdPtrGray;
  logic [PW-1:0] wrPtrGray;
  logic          memWriteEn;
  logic [A-1:0]  memAddrIn;
  logic [W-1:0]  memDataIn;

  fifo_wr_ctrl #(
    .FIFO_WIDTH(W), .FIFO_DEPTH(D), .ADDR_WIDTH(A), .ALMOST_FULL_MARGIN(M)
  ) dut (
    .wrClk(wrClk), .rst(rst), .wrEn(wrEn), .wrData(wrData),
    .wrFull(wrFull), .almostFull(almostFull), .wrErr(wrErr), .wrCount(wrCount),
    .rdPtrGray(rdPtrGray), .wrPtrGray(wrPtrGray),
    .memWriteEn(memWriteEn), .memAddrIn(memAddrIn), .memDataIn(memDataIn)
  );

  // clock / reset
  initial wrClk = 1'b0;
  always #5 wrClk = ~wrClk;

  int checks = 0;
  int errors = 0;

  // reference model: pointers as plain integers modulo 2*D
  int m_wr, m_rd, m_s1, m_s2, m_count;
  bit m_full, m_err, m_af;
  logic [W-1:0] exp_q[$];

  function automatic logic [PW-1:0] gray(input int b);
    int g;
    g = b ^ (b >> 1);
    return g[PW-1:0];
  endfunction

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_s1 = 0; m_s2 = 0; m_count = 0;
    m_full = 0; m_err = 0; m_af = 0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge wrClk);
    rst = 1'b1; wrEn = 1'b0; wrData = '0; rdPtrGray = '0;
    @(negedge wrClk);
    rst = 1'b0;
    model_reset();
  endtask

  // driver: one clock cycle starting and ending at a falling edge
  task automatic step(input bit we, input logic [W-1:0] d);
    bit acc;
    logic [W-1:0] exp_d;
    wrEn = we; wrData = d; rdPtrGray = gray(m_rd);
    #1;
    acc = we && !m_full;
    checks++;
    if (memWriteEn !== acc) begin
      errors++;
      $display("FAIL memWriteEn: got %0b expected %0b (wr=%0d)", memWriteEn, acc, m_wr);
    end
    if (acc) begin
      exp_q.push_back(d);
      exp_d = exp_q.pop_front();
      checks++;
      if (memAddrIn !== A'(m_wr % D) || memDataIn !== exp_d) begin
        errors++;
        $display("FAIL mem_port: got addr=%0d data=%h expected addr=%0d data=%h",
                 memAddrIn, memDataIn, m_wr % D, exp_d);
      end
    end
    @(posedge wrClk);
    if (we && m_full) m_err = 1;
    m_wr    = (m_wr + int'(acc)) % MOD;
    m_count = (m_wr - m_s2 + MOD) % MOD;
    m_full  = (m_count == D);
    m_af    = AF_EN && (m_count >= D - M);
    m_s2    = m_s1;
    m_s1    = m_rd;
    @(negedge wrClk);
    checks++;
    if (wrFull !== m_full || almostFull !== m_af || wrErr !== m_err ||
        wrCount !== PW'(m_count) || wrPtrGray !== gray(m_wr)) begin
      errors++;
      $display("FAIL regs: got full=%0b af=%0b err=%0b count=%0d gray=%h expected full=%0b af=%0b err=%0b count=%0d gray=%h",
               wrFull, almostFull, wrErr, wrCount, wrPtrGray,
               m_full, m_af, m_err, m_count, gray(m_wr));
    end
  endtask

  task automatic test_reset();
    @(negedge wrClk);
    rst = 1'b1; wrEn = 1'b1; wrData = 8'h3C; rdPtrGray = '0;
    #2;
    checks++;
    if ({wrFull, almostFull, wrErr, wrCount, wrPtrGray, memWriteEn} !== '0) begin
      errors++;
      $display("FAIL reset_state: got full=%0b af=%0b err=%0b count=%0d gray=%h we=%0b expected all 0",
               wrFull, almostFull, wrErr, wrCount, wrPtrGray, memWriteEn);
    end
    @(negedge wrClk);
    rst = 1'b0; wrEn = 1'b0;
    model_reset();
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 1; i <= D; i++) begin
      step(1'b1, W'($urandom));
      if (i == D - M - 1) begin
        checks++;
        if (almostFull !== 1'b0) begin
          errors++; $display("FAIL almost_full_59: got %0b expected 0", almostFull);
        end
      end
      if (i == D - M) begin
        checks++;
        if (almostFull !== AF_EN) begin
          errors++; $display("FAIL almost_full_60: got %0b expected %0b", almostFull, AF_EN);
        end
      end
    end
    checks++;
    if (wrFull !== 1'b1 || wrCount !== 7'd64 || wrPtrGray !== 7'h60) begin
      errors++;
      $display("FAIL fill_end: got full=%0b count=%0d gray=%h expected full=1 count=64 gray=60",
               wrFull, wrCount, wrPtrGray);
    end
  endtask

  task automatic test_overflow();
    step(1'b1, 8'hA5);
    checks++;
    if (wrErr !== 1'b1 || wrCount !== 7'd64) begin
      errors++;
      $display("FAIL overflow: got err=%0b count=%0d expected err=1 count=64", wrErr, wrCount);
    end
    step(1'b0, 8'h00);
    checks++;
    if (wrErr !== 1'b1) begin
      errors++; $display("FAIL overflow_sticky: got err=%0b expected 1", wrErr);
    end
  endtask

  task automatic test_drain_sync();
    m_rd = 1;
    for (int e = 1; e <= 3; e++) begin
      step(1'b0, 8'h00);
      checks++;
      if (wrFull !== (e < 3) || wrCount !== ((e < 3) ? 7'd64 : 7'd63)) begin
        errors++;
        $display("FAIL drain_edge%0d: got full=%0b count=%0d expected full=%0b count=%0d",
                 e, wrFull, wrCount, (e < 3), (e < 3) ? 64 : 63);
      end
    end
    wrEn = 1'b1; rdPtrGray = gray(m_rd);
    #1;
    checks++;
    if (memWriteEn !== 1'b1 || memAddrIn !== 6'd0) begin
      errors++;
      $display("FAIL drain_next_addr: got we=%0b addr=%0d expected we=1 addr=0", memWriteEn, memAddrIn);
    end
    step(1'b1, 8'h5A);
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < D; i++) step(1'b1, W'($urandom));
    m_rd = D;
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00);
    for (int i = 0; i < D; i++) step(1'b1, W'($urandom));
    checks++;
    if (wrPtrGray !== 7'h00 || wrFull !== 1'b1 || wrCount !== 7'd64) begin
      errors++;
      $display("FAIL wrap_end: got gray=%h full=%0b count=%0d expected gray=00 full=1 count=64",
               wrPtrGray, wrFull, wrCount);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, W'($urandom));
    wrEn = 1'b1; wrData = 8'h77;
    @(posedge wrClk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({wrFull, almostFull, wrErr, wrCount, wrPtrGray, memWriteEn} !== '0) begin
      errors++;
      $display("FAIL async_reset: got full=%0b af=%0b err=%0b count=%0d gray=%h we=%0b expected all 0",
               wrFull, almostFull, wrErr, wrCount, wrPtrGray, memWriteEn);
    end
    @(negedge wrClk);
    rst = 1'b0; rdPtrGray = '0;
    model_reset();
    #1;
    checks++;
    if (memWriteEn !== 1'b1 || memAddrIn !== 6'd0) begin
      errors++;
      $display("FAIL post_reset_addr: got we=%0b addr=%0d expected we=1 addr=0", memWriteEn, memAddrIn);
    end
    step(1'b1, 8'h11);
  endtask

  task automatic test_random();
    int wr_bias;
    do_reset();
    wr_bias = 3;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) wr_bias = $urandom_range(1, 4);
      if ($urandom_range(0, 4) < wr_bias && m_rd != m_wr && $urandom_range(0, 1) == 0)
        m_rd = m_rd;
      else if (m_rd != m_wr && $urandom_range(0, 2) == 0)
        m_rd = (m_rd + 1) % MOD;
      step($urandom_range(0, 4) < wr_bias, W'($urandom));
    end
  endtask

  initial begin
    rst = 1'b1; wrEn = 1'b0; wrData = '0; rdPtrGray = '0;
    model_reset();
    test_reset();
    test_fill();
    test_overflow();
    test_drain_sync();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
